// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversamples SCK/CS/MOSI on clk, receives bytes into an RX FIFO
// and shifts out bytes preloaded into a TX FIFO on MISO, MSB first.
module spi_peripheral #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  DEFAULT_RESP = 8'hFF
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       tx_wr,
  input  logic [7:0] tx_din,
  output logic       tx_full,
  output logic       tx_empty,
  input  logic       rx_rd,
  output logic [7:0] rx_dout,
  output logic       rx_data_avail,
  output logic       rx_overflow,
  output logic       tx_underrun,
  input  logic       flag_clr,
  output logic       busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sck_sync_q, sck_sync_d;
  logic [2:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        byte_done_q, byte_done_d;
  logic        rx_overflow_q, rx_overflow_d;
  logic        tx_underrun_q, tx_underrun_d;

  logic [7:0]  tx_mem_q [FIFO_DEPTH];
  logic [7:0]  tx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d, tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW:0] tx_cnt_q, tx_cnt_d;

  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [7:0]  rx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d, rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW:0] rx_cnt_q, rx_cnt_d;

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;
  logic load, tx_push, tx_pop, rx_push_req, rx_push, rx_pop, rx_full;
  logic [7:0] load_byte, rx_byte;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];

  assign tx_full       = (tx_cnt_q == DEPTH_C);
  assign tx_empty      = (tx_cnt_q == '0);
  assign rx_full       = (rx_cnt_q == DEPTH_C);
  assign rx_data_avail = (rx_cnt_q != '0);
  assign rx_dout       = rx_data_avail ? rx_mem_q[rx_rd_ptr_q] : '0;
  assign rx_overflow   = rx_overflow_q;
  assign tx_underrun   = tx_underrun_q;
  assign busy          = (state_q == SHIFT);
  assign spi_miso_oe   = (state_q == SHIFT);
  assign spi_miso      = (state_q == SHIFT) & tx_shift_q[7];

  assign load_byte = tx_empty ? DEFAULT_RESP : tx_mem_q[tx_rd_ptr_q];
  assign rx_byte   = {rx_shift_q, mosi_s};

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], spi_sck};
    cs_sync_d   = {cs_sync_q[1:0], spi_cs};
    mosi_sync_d = {mosi_sync_q[0], spi_mosi};
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    load        = 1'b0;
    rx_push_req = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = SHIFT;
          load        = 1'b1;
          bit_cnt_d   = '0;
          byte_done_d = 1'b0;
        end
      end
      SHIFT: begin
        // cs_rise must win over any sck event landing in the same cycle
        if (cs_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          byte_done_d = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = rx_byte[6:0];
          if (bit_cnt_q == 3'd7) begin
            rx_push_req = 1'b1;
            bit_cnt_d   = '0;
            byte_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (sck_fall) begin
          if (byte_done_q) begin
            load        = 1'b1;
            byte_done_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) tx_shift_d = load_byte;
  end

  always_comb begin
    tx_push = tx_wr & ~tx_full;
    tx_pop  = load & ~tx_empty;
    rx_pop  = rx_rd & rx_data_avail;
    rx_push = rx_push_req & (~rx_full | rx_rd);

    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = tx_din;
      tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
    end
    if (tx_pop) tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;

    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = rx_byte;
      rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
    end
    if (rx_pop) rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;

    rx_overflow_d = (rx_overflow_q & ~flag_clr) | (rx_push_req & ~rx_push);
    tx_underrun_d = (tx_underrun_q & ~flag_clr) | (load & tx_empty);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      sck_sync_q    <= 3'b000;
      cs_sync_q     <= 3'b111;
      mosi_sync_q   <= 2'b00;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      byte_done_q   <= 1'b0;
      rx_overflow_q <= 1'b0;
      tx_underrun_q <= 1'b0;
      tx_mem_q      <= '{default: '0};
      tx_rd_ptr_q   <= '0;
      tx_wr_ptr_q   <= '0;
      tx_cnt_q      <= '0;
      rx_mem_q      <= '{default: '0};
      rx_rd_ptr_q   <= '0;
      rx_wr_ptr_q   <= '0;
      rx_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_done_q   <= byte_done_d;
      rx_overflow_q <= rx_overflow_d;
      tx_underrun_q <= tx_underrun_d;
      tx_mem_q      <= tx_mem_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_mem_q      <= rx_mem_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_cnt_q      <= rx_cnt_d;
    end
  end

endmodule
